// File: rtl/dma_fifo_buf_if.sv
// Handshake/status bundle between the DMA interface (master) and the FIFO buffer (slave).
interface dma_fifo_buf_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_LOG2 = 2
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;
  logic                  full;
  logic                  afull;
  logic [DEPTH_LOG2:0]   count;
  logic                  last_wr;
  logic                  err_clr;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en, err_clr,
    input  rd_data, empty, full, afull, count, last_wr, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, err_clr,
    output rd_data, empty, full, afull, count, last_wr, overflow, underflow
  );
endinterface

// File: rtl/dma_fifo_buf.sv
// First-word-fall-through word FIFO between the DMA interface and DMA core.
// Sticky overflow/underflow flags are built only when DMA_FIFO_ERR_EN is defined.
module dma_fifo_buf #(
  parameter int DATA_WIDTH  = 16,
  parameter int DEPTH_LOG2  = 2,
  parameter int AFULL_LEVEL = 3
) (
  input  logic           clk,
  input  logic           rst,
  dma_fifo_buf_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AFULL_CNT = (DEPTH_LOG2+1)'(AFULL_LEVEL);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [DEPTH_LOG2-1:0]            wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]              count;
  logic                             last_wr;
  logic                             empty, full;
  logic                             wr_acc, rd_acc;

  // Status is derived from registered occupancy only, so no request-to-output path exists.
  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  assign wr_acc = bus.wr_en & ~full;
  assign rd_acc = bus.rd_en & ~empty;

  // Storage is left uncleared by reset; empty masks stale contents on rd_data.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      last_wr <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      if (wr_acc && !rd_acc)      count <= count + 1'b1;
      else if (rd_acc && !wr_acc) count <= count - 1'b1;
      if (wr_acc)      last_wr <= 1'b1;
      else if (rd_acc) last_wr <= 1'b0;
    end
  end

  assign bus.rd_data = empty ? '0 : mem[rd_ptr];
  assign bus.empty   = empty;
  assign bus.full    = full;
  assign bus.afull   = (count >= AFULL_CNT);
  assign bus.count   = count;
  assign bus.last_wr = last_wr;

`ifdef DMA_FIFO_ERR_EN
  logic overflow, underflow;

  // A fresh error in the clear cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  & ~bus.err_clr) | (bus.wr_en & full);
      underflow <= (underflow & ~bus.err_clr) | (bus.rd_en & empty);
    end
  end

  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;
`else
  logic err_clr_unused;
  assign err_clr_unused = bus.err_clr;
  assign bus.overflow   = 1'b0;
  assign bus.underflow  = 1'b0;
`endif
endmodule
